// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: receive FSM states and oversampling constants.
// One bit period is OVERSAMPLE rx_en ticks; the tick counter spans exactly one bit period.
package uart_pkg;

   localparam int unsigned OVERSAMPLE = 16;
   localparam int unsigned TICK_W     = $clog2(OVERSAMPLE);

   // Mid-point of the start bit and last tick of every later bit period.
   localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(7);
   localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(15);

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Both flops reset to RESET_VAL so the output is defined while rst_n is low.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: 8N1 by default, LSB first, with ready/acknowledge handshake,
// framing-error flag and sticky overrun flag.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx_en,
   input  logic                 rx,
   input  logic                 rdy_clr,
   output logic [DATA_BITS-1:0] data,
   output logic                 rdy,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int unsigned BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

   logic rx_s;

   rx_state_t            state_q, state_d;
   logic [TICK_W-1:0]    tick_q, tick_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 rdy_q, rdy_d;
   logic                 ferr_q, ferr_d;
   logic                 ovr_q, ovr_d;

   sync_2ff #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx),
      .q     (rx_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         rdy_q   <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         rdy_q   <= rdy_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      rdy_d   = rdy_q;
      ferr_d  = ferr_q;
      ovr_d   = ovr_q;

      // Acknowledge first so a coinciding byte completion below overrides it.
      if (rdy_clr) begin
         rdy_d = 1'b0;
      end

      if (rx_en) begin
         unique case (state_q)
            StIdle: begin
               if (!rx_s) begin
                  state_d = StStart;
                  tick_d  = '0;
               end
            end

            StStart: begin
               if (tick_q == MID_TICK) begin
                  tick_d = '0;
                  if (!rx_s) begin
                     state_d = StData;
                     bit_d   = '0;
                  end else begin
                     // Line went back high before mid-bit: treat as a glitch.
                     state_d = StIdle;
                  end
               end else begin
                  tick_d = tick_q + TICK_W'(1);
               end
            end

            StData: begin
               if (tick_q == LAST_TICK) begin
                  tick_d  = '0;
                  shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                  if (bit_q == LAST_BIT) begin
                     bit_d   = '0;
                     state_d = StStop;
                  end else begin
                     bit_d = bit_q + BIT_W'(1);
                  end
               end else begin
                  tick_d = tick_q + TICK_W'(1);
               end
            end

            StStop: begin
               if (tick_q == LAST_TICK) begin
                  tick_d  = '0;
                  state_d = StIdle;
                  if (rx_s) begin
                     data_d = shift_q;
                     rdy_d  = 1'b1;
                     ferr_d = 1'b0;
                     if (rdy_q) begin
                        ovr_d = 1'b1;
                     end
                  end else begin
                     ferr_d = 1'b1;
                  end
               end else begin
                  tick_d = tick_q + TICK_W'(1);
               end
            end

            default: begin
               state_d = StIdle;
               tick_d  = '0;
               bit_d   = '0;
            end
         endcase
      end
   end

   assign data      = data_q;
   assign rdy       = rdy_q;
   assign frame_err = ferr_q;
   assign overrun   = ovr_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: a frame-level model predicts the outputs after each
// frame, and a monitor compares them whenever the receiver drops back to idle.
module tb_uart_rx;

   // The receiver only reacts to rx_en, so a short tick spacing keeps runtime small.
   localparam int TICK_PERIOD = 8;
   localparam int BIT_TICKS   = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_en = 1'b0;
   logic       rx = 1'b1;
   logic       rdy_clr = 1'b0;
   logic [7:0] data;
   logic       rdy;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   uart_rx #(
      .DATA_BITS (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_en     (rx_en),
      .rx        (rx),
      .rdy_clr   (rdy_clr),
      .data      (data),
      .rdy       (rdy),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   always #10 clk = ~clk;

   typedef struct packed {
      logic [7:0] data;
      logic       rdy;
      logic       ferr;
      logic       ovr;
   } exp_t;

   exp_t exp_q[$];

   // Frame-level reference state.
   logic [7:0] m_data;
   logic       m_rdy;
   logic       m_ferr;
   logic       m_ovr;

   int n_checks = 0;
   int n_fail   = 0;

   logic en_seen;
   always @(posedge clk) en_seen <= rx_en;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
      end
   endtask

   // One rx_en pulse at the end of a TICK_PERIOD window, optionally with rdy_clr on the same clk.
   task automatic tick(input logic clr);
      repeat (TICK_PERIOD - 1) @(negedge clk);
      rx_en   = 1'b1;
      rdy_clr = clr;
      @(negedge clk);
      rx_en   = 1'b0;
      rdy_clr = 1'b0;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick(1'b0);
   endtask

   task automatic push_model();
      exp_t e;
      e.data = m_data;
      e.rdy  = m_rdy;
      e.ferr = m_ferr;
      e.ovr  = m_ovr;
      exp_q.push_back(e);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_data"}, data, 0);
      check({tag, "_rdy"}, rdy, 0);
      check({tag, "_frame_err"}, frame_err, 0);
      check({tag, "_overrun"}, overrun, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   task automatic model_reset();
      m_data = '0;
      m_rdy  = 1'b0;
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
   endtask

   task automatic apply_reset(input string tag);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero(tag);
      model_reset();
      rst_n = 1'b1;
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      rdy_clr = 1'b1;
      @(negedge clk);
      rdy_clr = 1'b0;
      m_rdy   = 1'b0;
   endtask

   // Drive a full frame; the stop bit is sampled on its 9th tick, where clr may coincide.
   task automatic send_frame(input logic [7:0] b, input logic stop, input logic clr);
      if (stop) begin
         m_ovr  = m_ovr | m_rdy;
         m_data = b;
         m_rdy  = 1'b1;
         m_ferr = 1'b0;
      end else begin
         m_ferr = 1'b1;
         if (clr) m_rdy = 1'b0;
      end
      push_model();
      rx = 1'b0;
      ticks(BIT_TICKS);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         ticks(BIT_TICKS);
      end
      rx = stop;
      ticks(BIT_TICKS / 2);
      tick(clr);
      rx = 1'b1;
      ticks(BIT_TICKS / 2 - 1);
   endtask

   // Monitor: every return to idle is one observable frame outcome.
   initial begin : monitor
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev = 1'b0;
         end else begin
            if (prev && !busy) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_idle: got an idle transition, expected none at %0t",
                           $time);
               end else begin
                  e = exp_q.pop_front();
                  check("data", data, e.data);
                  check("rdy", rdy, e.rdy);
                  check("frame_err", frame_err, e.ferr);
                  check("overrun", overrun, e.ovr);
                  check("update_on_tick", en_seen, 1);
               end
            end
            prev = busy;
         end
      end
   end

   initial begin : watchdog
      #4_000_000;
      $display("FAIL watchdog: got no completion, expected the bench to finish");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      logic [7:0] b;
      logic       stop;
      logic       clr;
      int         gap;

      model_reset();
      apply_reset("reset");
      ticks(4);

      send_frame(8'h55, 1'b1, 1'b0);
      ticks(2);

      // Glitch: line low for 4 ticks only; no output change expected.
      push_model();
      rx = 1'b0;
      ticks(4);
      rx = 1'b1;
      ticks(12);

      apply_reset("reset2");
      ticks(2);
      send_frame(8'hA3, 1'b0, 1'b0);
      ticks(2);

      send_frame(8'h12, 1'b1, 1'b0);
      send_frame(8'h34, 1'b1, 1'b0);
      ticks(2);
      pulse_clr();
      check("clr_rdy", rdy, m_rdy);
      check("clr_overrun_sticky", overrun, 1);
      check("clr_data", data, 8'h34);

      send_frame(8'h77, 1'b1, 1'b0);
      send_frame(8'h9C, 1'b1, 1'b1);
      ticks(2);
      check("collide_rdy", rdy, 1);
      check("collide_data", data, 8'h9C);

      // Reset in the middle of data bit 3 of 0xFF.
      rx = 1'b0;
      ticks(BIT_TICKS);
      rx = 1'b1;
      ticks(3 * BIT_TICKS + 4);
      @(negedge clk);
      #3 rst_n = 1'b0;
      #1 check_all_zero("midframe_reset");
      model_reset();
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      ticks(4);
      check("post_reset_idle", busy, 0);
      send_frame(8'h0F, 1'b1, 1'b0);
      ticks(2);
      check("post_reset_data", data, 8'h0F);
      check("post_reset_rdy", rdy, 1);

      for (int n = 0; n < 12; n++) begin
         b    = 8'($urandom);
         stop = ($urandom_range(0, 3) != 0);
         clr  = 1'($urandom_range(0, 1));
         gap  = int'($urandom_range(0, 2));
         send_frame(b, stop, clr);
         ticks(gap);
         if ($urandom_range(0, 2) == 0) pulse_clr();
      end

      ticks(4);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 DATA_BITS, 8, number of data bits per frame, LSB first, no parity.
REQ-002 OVERSAMPLE, 16, rx_en ticks per bit period.
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rx_en  input  1  one-clk-wide oversample tick from the baud generator (16x baud).
REQ-006 rx  input  1  serial line, idle high, asynchronous to clk.
REQ-007 rdy_clr  input  1  one-clk pulse from the consumer acknowledging data.
REQ-008 data  output  DATA_BITS  last correctly framed byte.
REQ-009 rdy  output  1  high while an unacknowledged byte is in data.
REQ-010 frame_err  output  1  stop bit of the most recent frame sampled low.
REQ-011 overrun  output  1  sticky; a byte completed while rdy was already high.
REQ-012 busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer (flops reset to 1) before use; rx_s denotes its output.
REQ-014 The state machine SHALL have the states IDLE, START, DATA and STOP, plus a 4-bit tick counter and a bit index; all of them SHALL advance only on cycles with rx_en=1 and hold otherwise.
REQ-015 IDLE: on rx_en with rx_s=0, go to START with the tick counter at 0.
REQ-016 START: increment the tick counter on each rx_en; at the 8th tick (counter=7), if rx_s=0, go to DATA with the counter and bit index at 0; otherwise return to IDLE (glitch rejection, no output change).
REQ-017 DATA: at counter=15, shift rx_s into the MSB of the shift register (shift right), clear the counter and increment the bit index; after the DATA_BITS-th sample, go to STOP.
REQ-018 STOP: at counter=15, if rx_s=1, load data from the shift register, set rdy=1 and clear frame_err; if rx_s=0, set frame_err=1 and leave data and rdy unchanged; in both cases go to IDLE.
REQ-019 Outputs SHALL update on the clk edge that consumes the stop-bit sampling tick, i.e. 1 clk of latency after that tick.
REQ-020 rdy_clr SHALL clear rdy on the next clk edge; when rdy_clr coincides with a byte completion, set wins and rdy stays 1.
REQ-021 A good frame completing while rdy=1 SHALL overwrite data and set overrun; overrun SHALL clear only on reset.
REQ-022 A low rx_s in IDLE after STOP SHALL start a new frame with no idle gap required (back-to-back frames).
REQ-023 The tick counter SHALL wrap 15->0 only under the rules above; no other arithmetic wrap is permitted.

Reset
REQ-024 While rst_n=0, the block SHALL hold: state=IDLE, counters=0, shift register=0, data=0, rdy=0, frame_err=0, overrun=0, busy=0, synchronizer flops=1.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately; after release, the receiver SHALL wait in IDLE for a new falling edge.

Structure
REQ-026 Shared package uart_pkg SHALL hold the state enum rx_state_t, OVERSAMPLE=16, MID_TICK=7 and LAST_TICK=15.
REQ-027 The synchronizer SHALL be a sub-module named sync_2ff; everything else SHALL stay in uart_rx.

Verification
REQ-028 Bench: clk 50 MHz; rx_en every 326 clks; one bit = 16 ticks. Send 0x55 with a good stop bit -> data=0x55, rdy=1, frame_err=0, 1 clk after the stop-bit mid tick.
REQ-029 Pull rx low for 4 ticks, then high -> state returns to IDLE at tick 8; rdy, data and frame_err unchanged.
REQ-030 Send 0xA3 with the stop bit low -> frame_err=1, rdy=0, data still 0.
REQ-031 Send 0x12 then 0x34 back-to-back with no rdy_clr -> data=0x34, rdy=1, overrun=1; then pulse rdy_clr -> rdy=0, overrun stays 1.
REQ-032 Pulse rdy_clr on the same clk as a byte completion -> rdy=1 with the new data.
REQ-033 Assert rst_n=0 during data bit 3 of 0xFF -> all outputs go to 0 immediately; after release, send 0x0F -> data=0x0F, rdy=1.
